// File: rtl/temp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | temp_pkg : shared types, defaults and helpers for the temperature monitor  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package temp_pkg;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PENDING = 2'd1,
      ALARM   = 2'd2
   } temp_state_e;

   localparam logic [7:0] TEMP_THR_HI_DEF = 8'h25;
   localparam logic [7:0] TEMP_THR_LO_DEF = 8'h20;

   // Hit counter holds CONFIRM values up to 15.
   localparam int HIT_W = 4;

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/temp_ch_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | temp_ch_fsm : per-channel block averager and hysteresis alarm FSM          |
// | Optional macro TEMP_ALARM_LATCH_EN makes alarm exit require clr.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module temp_ch_fsm
   import temp_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int AVG_LOG2 = 2,
   parameter int CONFIRM  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             smp_valid,
   input  logic [WIDTH-1:0] smp_data,
   input  logic [WIDTH-1:0] thr_hi,
   input  logic [WIDTH-1:0] thr_lo,
   input  logic             clr,
   output logic             avg_done,
   output logic [WIDTH-1:0] avg_val,
   output logic             alarm
);

   localparam int ACC_W = WIDTH + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [ACC_W-1:0] w_sum;
   logic             w_last;

   logic             ev_q;
   logic [WIDTH-1:0] avgr_q;
   temp_state_e      state_q, state_d;
   logic [HIT_W-1:0] hit_q, hit_d;
   logic             w_over, w_under, w_exit;
   logic [HIT_W-1:0] w_hit_inc;

   assign w_sum = acc_q + ACC_W'(smp_data);

   generate
      if (AVG_LOG2 == 0) begin : g_no_avg
         logic w_cnt_unused;
         assign w_cnt_unused = ^smp_cnt_q;
         assign w_last       = 1'b1;
      end else begin : g_avg
         assign w_last = (smp_cnt_q == {CNT_W{1'b1}});
      end
   endgenerate

   assign avg_done = smp_valid && w_last;
   assign avg_val  = w_sum[ACC_W-1:AVG_LOG2];

   always_comb begin
      acc_d     = acc_q;
      smp_cnt_d = smp_cnt_q;
      if (smp_valid) begin
         acc_d     = w_last ? '0 : w_sum;
         smp_cnt_d = w_last ? '0 : smp_cnt_q + 1'b1;
      end
   end

   assign w_over    = (avgr_q > thr_hi);
   assign w_under   = (avgr_q < thr_lo);
   assign w_hit_inc = hit_q + 1'b1;

`ifdef TEMP_ALARM_LATCH_EN
   // Exit needs clr and the most recent average below thr_lo, including one
   // being evaluated on the same cycle.
   logic below_q;
   assign w_exit = clr && (ev_q ? w_under : below_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      below_q <= 1'b0;
      else if (ev_q) below_q <= w_under;
   end
`else
   logic w_clr_unused;
   assign w_clr_unused = clr;
   assign w_exit       = ev_q && w_under;
`endif

   always_comb begin
      state_d = state_q;
      hit_d   = hit_q;
      case (state_q)
         NORMAL: begin
            if (ev_q && w_over) begin
               hit_d = HIT_W'(1);
               if (CONFIRM <= 1) state_d = ALARM;
               else              state_d = PENDING;
            end
         end
         PENDING: begin
            if (ev_q) begin
               if (w_over) begin
                  hit_d = w_hit_inc;
                  if (w_hit_inc == HIT_W'(CONFIRM)) state_d = ALARM;
               end else begin
                  hit_d   = '0;
                  state_d = NORMAL;
               end
            end
         end
         ALARM: begin
            if (w_exit) begin
               hit_d   = '0;
               state_d = NORMAL;
            end
         end
         default: begin
            hit_d   = '0;
            state_d = NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q     <= '0;
         smp_cnt_q <= '0;
         ev_q      <= 1'b0;
         avgr_q    <= '0;
         state_q   <= NORMAL;
         hit_q     <= '0;
      end else begin
         acc_q     <= acc_d;
         smp_cnt_q <= smp_cnt_d;
         ev_q      <= avg_done;
         if (avg_done) avgr_q <= avg_val;
         state_q   <= state_d;
         hit_q     <= hit_d;
      end
   end

   assign alarm = (state_q == ALARM);

endmodule
`default_nettype wire

// File: rtl/temp_alarm_mon.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | temp_alarm_mon : multi-channel averaging temperature alarm monitor          |
// | Optional macro TEMP_ALARM_LATCH_EN latches alarms until clr.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module temp_alarm_mon
   import temp_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NCH      = 2,
   parameter int AVG_LOG2 = 2,
   parameter int CONFIRM  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic [ch_idx_w(NCH)-1:0] s_ch,
   input  logic [WIDTH-1:0]         s_data,
   input  logic [WIDTH-1:0]         thr_hi,
   input  logic [WIDTH-1:0]         thr_lo,
   input  logic                     clr,
   output logic                     avg_valid,
   output logic [ch_idx_w(NCH)-1:0] avg_ch,
   output logic [WIDTH-1:0]         avg_data,
   output logic [NCH-1:0]           alarm,
   output logic                     r,
   output logic                     g
);

   localparam int            CHW     = ch_idx_w(NCH);
   localparam logic [CHW:0]  NCH_EXT = (CHW+1)'(NCH);

   logic                 w_accept;
   logic [NCH-1:0]       w_sel;
   logic [NCH-1:0]       w_done;
   logic [WIDTH-1:0]     w_avg [NCH];

   logic                 avg_valid_q, avg_valid_d;
   logic [CHW-1:0]       avg_ch_q, avg_ch_d;
   logic [WIDTH-1:0]     avg_data_q, avg_data_d;

   // Out-of-range tags are dropped before reaching any channel.
   assign w_accept = s_valid && ({1'b0, s_ch} < NCH_EXT);

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         assign w_sel[i] = w_accept && (s_ch == CHW'(i));

         temp_ch_fsm #(
            .WIDTH    (WIDTH),
            .AVG_LOG2 (AVG_LOG2),
            .CONFIRM  (CONFIRM)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .smp_valid (w_sel[i]),
            .smp_data  (s_data),
            .thr_hi    (thr_hi),
            .thr_lo    (thr_lo),
            .clr       (clr),
            .avg_done  (w_done[i]),
            .avg_val   (w_avg[i]),
            .alarm     (alarm[i])
         );
      end
   endgenerate

   // At most one channel completes per cycle since only one sample arrives.
   always_comb begin
      avg_valid_d = 1'b0;
      avg_ch_d    = avg_ch_q;
      avg_data_d  = avg_data_q;
      for (int k = 0; k < NCH; k++) begin
         if (w_done[k]) begin
            avg_valid_d = 1'b1;
            avg_ch_d    = CHW'(k);
            avg_data_d  = w_avg[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         avg_valid_q <= 1'b0;
         avg_ch_q    <= '0;
         avg_data_q  <= '0;
      end else begin
         avg_valid_q <= avg_valid_d;
         avg_ch_q    <= avg_ch_d;
         avg_data_q  <= avg_data_d;
      end
   end

   assign avg_valid = avg_valid_q;
   assign avg_ch    = avg_ch_q;
   assign avg_data  = avg_data_q;
   assign r         = |alarm;
   assign g         = ~(|alarm);

endmodule
`default_nettype wire

// File: tb/tb_temp_alarm_mon.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_temp_alarm_mon : directed self-checking bench for temp_alarm_mon        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_temp_alarm_mon;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       s_valid = 1'b0;
   logic [0:0] s_ch   = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic [7:0] thr_hi = 8'h25;
   logic [7:0] thr_lo = 8'h20;
   logic       clr    = 1'b0;

   logic       avg_valid, r, g;
   logic [0:0] avg_ch;
   logic [7:0] avg_data;
   logic [1:0] alarm;

   logic       avg_valid1, r1, g1;
   logic [0:0] avg_ch1;
   logic [7:0] avg_data1;
   logic [0:0] alarm1;

   int n_vec = 0;
   int n_bad = 0;

`ifdef TEMP_ALARM_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   always #5 clk = ~clk;

   temp_alarm_mon #(.WIDTH(8), .NCH(2), .AVG_LOG2(2), .CONFIRM(2)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .clr(clr),
      .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data),
      .alarm(alarm), .r(r), .g(g)
   );

   // Single-channel build sharing the stimulus: every s_ch=1 sample is out of range.
   temp_alarm_mon #(.WIDTH(8), .NCH(1), .AVG_LOG2(2), .CONFIRM(2)) u_dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .clr(clr),
      .avg_valid(avg_valid1), .avg_ch(avg_ch1), .avg_data(avg_data1),
      .alarm(alarm1), .r(r1), .g(g1)
   );

   task automatic drive(input logic v, input logic [0:0] ch, input logic [7:0] d);
      @(negedge clk);
      s_valid = v;
      s_ch    = ch;
      s_data  = d;
   endtask

   // Returns on the negedge after the completing sample, i.e. the avg_valid cycle.
   task automatic send_block(input logic [0:0] ch, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
      drive(1'b1, ch, d0);
      drive(1'b1, ch, d1);
      drive(1'b1, ch, d2);
      drive(1'b1, ch, d3);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL reset_alarm: got %b want 00", alarm); end
         n_vec++; if (r !== 1'b0) begin n_bad++; $display("FAIL reset_r: got %b want 0", r); end
         n_vec++; if (g !== 1'b1) begin n_bad++; $display("FAIL reset_g: got %b want 1", g); end
         n_vec++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
         n_vec++; if (avg_data !== 8'h00) begin n_bad++; $display("FAIL reset_avg_data: got %h want 00", avg_data); end
         s_valid = 1'($urandom_range(0, 1));
         s_ch    = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom_range(0, 255));
         clr     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      s_valid = 1'b0;
      clr     = 1'b0;
      rst     = 1'b1;
   endtask

   task automatic test_averaging();
      drive(1'b1, 1'b0, 8'h10);
      drive(1'b1, 1'b0, 8'h11);
      drive(1'b1, 1'b0, 8'h12);
      drive(1'b1, 1'b0, 8'h13);
      n_vec++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL avg_early: got %b want 0", avg_valid); end
      drive(1'b0, 1'b0, 8'h00);
      n_vec++; if (avg_valid !== 1'b1) begin n_bad++; $display("FAIL avg_valid: got %b want 1", avg_valid); end
      n_vec++; if (avg_ch !== 1'b0) begin n_bad++; $display("FAIL avg_ch: got %0d want 0", avg_ch); end
      n_vec++; if (avg_data !== 8'h11) begin n_bad++; $display("FAIL avg_data: got %h want 11", avg_data); end
      @(negedge clk);
      n_vec++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL avg_strobe: got %b want 0", avg_valid); end
      n_vec++; if (avg_data !== 8'h11) begin n_bad++; $display("FAIL avg_hold: got %h want 11", avg_data); end
   endtask

   task automatic test_confirm();
      send_block(1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
      n_vec++; if (avg_ch !== 1'b1 || avg_data !== 8'h30) begin n_bad++; $display("FAIL conf_avg1: got ch%0d %h want ch1 30", avg_ch, avg_data); end
      @(negedge clk);
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL conf_first_hit: got %b want 00", alarm); end
      send_block(1'b1, 8'h24, 8'h24, 8'h24, 8'h24);
      @(negedge clk);
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL conf_break: got %b want 00", alarm); end
      send_block(1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
      @(negedge clk);
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL conf_restart: got %b want 00", alarm); end
      send_block(1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL conf_latency: got %b want 00", alarm); end
      @(negedge clk);
      n_vec++; if (alarm !== 2'b10) begin n_bad++; $display("FAIL conf_alarm: got %b want 10", alarm); end
      n_vec++; if (r !== 1'b1 || g !== 1'b0) begin n_bad++; $display("FAIL conf_rg: got r%b g%b want r1 g0", r, g); end
   endtask

   task automatic test_hysteresis();
      send_block(1'b1, 8'h22, 8'h22, 8'h22, 8'h22);
      @(negedge clk);
      n_vec++; if (alarm !== 2'b10) begin n_bad++; $display("FAIL hyst_hold: got %b want 10", alarm); end
      send_block(1'b1, 8'h1F, 8'h1F, 8'h1F, 8'h1F);
      @(negedge clk);
      n_vec++; if (alarm !== (LATCH ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL hyst_exit: got %b want %b", alarm, LATCH ? 2'b10 : 2'b00); end
      n_vec++; if (g !== !LATCH) begin n_bad++; $display("FAIL hyst_g: got %b want %b", g, !LATCH); end
   endtask

`ifdef TEMP_ALARM_LATCH_EN
   task automatic test_latch();
      repeat (3) @(negedge clk);
      n_vec++; if (alarm !== 2'b10) begin n_bad++; $display("FAIL latch_noclr: got %b want 10", alarm); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL latch_clr: got %b want 00", alarm); end
      send_block(1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
      @(negedge clk);
      n_vec++; if (alarm !== 2'b00) begin n_bad++; $display("FAIL latch_pend: got %b want 00", alarm); end
      send_block(1'b1, 8'h30, 8'h30, 8'h30, 8'h30);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_vec++; if (alarm !== 2'b10) begin n_bad++; $display("FAIL latch_entry_wins: got %b want 10", alarm); end
   endtask
`endif

   task automatic test_isolation();
      drive(1'b1, 1'b0, 8'h40);
      drive(1'b1, 1'b1, 8'h08);
      drive(1'b1, 1'b0, 8'h41);
      drive(1'b1, 1'b1, 8'h0C);
      drive(1'b1, 1'b0, 8'h42);
      drive(1'b1, 1'b1, 8'h10);
      drive(1'b1, 1'b0, 8'h43);
      n_vec++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL iso_early: got %b want 0", avg_valid); end
      drive(1'b1, 1'b1, 8'h14);
      n_vec++; if (avg_valid !== 1'b1 || avg_ch !== 1'b0) begin n_bad++; $display("FAIL iso_ch0_tag: got v%b ch%0d want v1 ch0", avg_valid, avg_ch); end
      n_vec++; if (avg_data !== 8'h41) begin n_bad++; $display("FAIL iso_ch0_data: got %h want 41", avg_data); end
      n_vec++; if (avg_valid1 !== 1'b1 || avg_data1 !== 8'h41) begin n_bad++; $display("FAIL iso_n1_ch0: got v%b %h want v1 41", avg_valid1, avg_data1); end
      drive(1'b0, 1'b0, 8'h00);
      n_vec++; if (avg_valid !== 1'b1 || avg_ch !== 1'b1) begin n_bad++; $display("FAIL iso_ch1_tag: got v%b ch%0d want v1 ch1", avg_valid, avg_ch); end
      n_vec++; if (avg_data !== 8'h0E) begin n_bad++; $display("FAIL iso_ch1_data: got %h want 0e", avg_data); end
      n_vec++; if (avg_valid1 !== 1'b0) begin n_bad++; $display("FAIL iso_drop: got %b want 0", avg_valid1); end
      n_vec++; if (avg_data1 !== 8'h41) begin n_bad++; $display("FAIL iso_drop_hold: got %h want 41", avg_data1); end
      @(negedge clk);
      n_vec++; if (alarm[0] !== 1'b0 || alarm1 !== 1'b0) begin n_bad++; $display("FAIL iso_alarm0: got %b/%b want 0/0", alarm[0], alarm1); end
   endtask

   task automatic test_boundary();
      send_block(1'b0, 8'h25, 8'h25, 8'h25, 8'h25);
      @(negedge clk);
      n_vec++; if (alarm[0] !== 1'b0) begin n_bad++; $display("FAIL bnd_eq_hi: got %b want 0", alarm[0]); end
      send_block(1'b0, 8'h26, 8'h26, 8'h26, 8'h26);
      @(negedge clk);
      n_vec++; if (alarm[0] !== 1'b0) begin n_bad++; $display("FAIL bnd_pend: got %b want 0", alarm[0]); end
      send_block(1'b0, 8'h26, 8'h26, 8'h26, 8'h26);
      @(negedge clk);
      n_vec++; if (alarm[0] !== 1'b1) begin n_bad++; $display("FAIL bnd_enter: got %b want 1", alarm[0]); end
      send_block(1'b0, 8'h20, 8'h20, 8'h20, 8'h23);
      n_vec++; if (avg_data !== 8'h20) begin n_bad++; $display("FAIL bnd_trunc: got %h want 20", avg_data); end
      @(negedge clk);
      n_vec++; if (alarm[0] !== 1'b1) begin n_bad++; $display("FAIL bnd_eq_lo: got %b want 1", alarm[0]); end
      send_block(1'b0, 8'h1F, 8'h1F, 8'h1F, 8'h1F);
      @(negedge clk);
      n_vec++; if (alarm[0] !== LATCH) begin n_bad++; $display("FAIL bnd_exit: got %b want %b", alarm[0], LATCH); end
   endtask

   task automatic test_reset_midblock();
      drive(1'b1, 1'b0, 8'h80);
      drive(1'b1, 1'b0, 8'h80);
      @(negedge clk);
      s_valid = 1'b0;
      rst     = 1'b0;
      #1;
      n_vec++; if (avg_data !== 8'h00) begin n_bad++; $display("FAIL async_avg_data: got %h want 00", avg_data); end
      n_vec++; if (alarm !== 2'b00 || g !== 1'b1) begin n_bad++; $display("FAIL async_alarm: got %b g%b want 00 g1", alarm, g); end
      @(negedge clk);
      rst = 1'b1;
      send_block(1'b0, 8'h10, 8'h10, 8'h10, 8'h10);
      n_vec++; if (avg_valid !== 1'b1 || avg_data !== 8'h10) begin n_bad++; $display("FAIL mid_discard: got v%b %h want v1 10", avg_valid, avg_data); end
      n_vec++; if (avg_data1 !== 8'h10) begin n_bad++; $display("FAIL mid_discard_n1: got %h want 10", avg_data1); end
   endtask

   initial begin
      test_reset();
      test_averaging();
      test_confirm();
      test_hysteresis();
`ifdef TEMP_ALARM_LATCH_EN
      test_latch();
`endif
      test_isolation();
      test_boundary();
      test_reset_midblock();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/temp_alarm_mon.md
# temp_alarm_mon

Parametrised multi-channel temperature alarm monitor. It sits between the MCP ADC reader and the red/green LED demux. It accepts tagged temperature samples, block-averages them per channel, and runs a per-channel hysteresis alarm state machine with a consecutive-hit confirmation filter. It drives the per-channel alarm flags and the aggregate red/green indication, replacing the single fixed `> 0x25` compare.

## Interface
Parameters:
- WIDTH, 8, sample/threshold width in bits (unsigned)
- NCH, 2, number of channels (1..16)
- AVG_LOG2, 2, log2 of samples per average block (0 = no averaging)
- CONFIRM, 2, consecutive over-threshold averages needed to enter ALARM (1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  sample strobe, one cycle per sample
- s_ch  in  $clog2(NCH) (min 1)  channel tag of sample
- s_data  in  WIDTH  temperature sample
- thr_hi  in  WIDTH  alarm-entry threshold (strict greater-than)
- thr_lo  in  WIDTH  alarm-exit threshold (strict less-than)
- clr  in  1  alarm clear pulse (effective only with latch feature)
- avg_valid  out  1  one-cycle strobe: new average available
- avg_ch  out  $clog2(NCH)  channel of avg_data
- avg_data  out  WIDTH  block average
- alarm  out  NCH  per-channel alarm state (1 = ALARM)
- r  out  1  red LED: OR of alarm
- g  out  1  green LED: NOR of alarm

## Operation
- Sample accepted when s_valid=1 and s_ch<NCH; s_ch>=NCH is dropped silently with no state change.
- Per channel: accumulator of WIDTH+AVG_LOG2 bits plus a sample counter of AVG_LOG2 bits. Accumulation never overflows.
- When the 2^AVG_LOG2-th sample of a block is accepted: avg = (acc + s_data) >> AVG_LOG2 (truncating). The accumulator and counter reset to 0 for the next block.
- Per-channel FSM, states NORMAL, PENDING, ALARM, with hit counter cnt:
  - NORMAL: avg>thr_hi → cnt=1; go to ALARM if CONFIRM=1, else go to PENDING. Otherwise stay.
  - PENDING: avg>thr_hi → cnt+1; go to ALARM when cnt reaches CONFIRM. avg<=thr_hi → NORMAL, cnt=0.
  - ALARM: avg<thr_lo → NORMAL, cnt=0. Otherwise stay. Values between thr_lo and thr_hi hold the alarm (hysteresis).
- FSM transitions occur only on that channel's avg_valid; other channels are untouched.
- thr_lo>=thr_hi is not rejected; the rules above apply literally.
- Thresholds are sampled on the avg_valid cycle; changing them mid-block is legal.
- alarm[i] = (state_i==ALARM). r/g are combinational from the registered alarm flags.

## Timing
- Reset (rst=0, asynchronous): all accumulators, counters and cnt = 0; all FSMs = NORMAL. Outputs: avg_valid=0, avg_ch=0, avg_data=0, alarm=0, r=0, g=1.
- avg_valid/avg_ch/avg_data are registered. They assert on the cycle after the edge that accepts the block-completing sample (latency 1). avg_data holds its value until the next average.
- alarm updates on the edge after avg_valid (latency 2 from the completing sample).
- Back-to-back samples every cycle, on any channel mix, are fully supported; there is no backpressure.
- Reset deasserting mid-block discards the partial block.

## Configuration
- TEMP_ALARM_LATCH_EN defined:
  - ALARM→NORMAL additionally requires clr. Exit happens on a clr cycle when the most recent average for that channel was <thr_lo.
  - A channel's "below thr_lo" flag is stored per channel.
  - clr coinciding with an ALARM entry on the same edge: entry wins; alarm stays set.
- Not defined: clr is ignored and exit is automatic as described in Operation.

## Structure
- Package temp_pkg: state enum (NORMAL, PENDING, ALARM), channel-index width function, shared default thresholds (TEMP_THR_HI_DEF=8'h25, TEMP_THR_LO_DEF=8'h20).
- Sub-module temp_ch_fsm: one instance per channel via generate. It holds the accumulator, sample counter, hit counter, FSM and latch flag.
- The top contains the channel decode, the average output register mux and the r/g reduction.

## Test plan
All scenarios use WIDTH=8, NCH=2, AVG_LOG2=2, CONFIRM=2, thr_hi=0x25, thr_lo=0x20.
- Reset: hold rst=0 with random stimulus → alarm=0, r=0, g=1, avg_valid=0.
- Averaging: ch0 samples 0x10,0x11,0x12,0x13 → one avg_valid, avg_ch=0, avg_data=0x11 (0x46>>2), exactly 1 cycle after the 4th sample.
- Confirmation: ch1 averages 0x30, then 0x24 → alarm[1] stays 0. Then 0x30, 0x30 → alarm[1]=1, r=1, g=0, two cycles after the completing sample.
- Hysteresis: ch1 in ALARM, averages 0x22 → alarm held; then 0x1F → alarm[1]=0, g=1.
- Channel isolation and invalid tag: interleave ch0/ch1 samples every cycle plus s_ch=1 on NCH=1 build → per-channel averages correct; the out-of-range tag is dropped.
- Latched mode (TEMP_ALARM_LATCH_EN): alarm set, average 0x10, no clr → alarm stays 1. Pulse clr → alarm=0 next edge. clr on the same edge as a new entry → alarm=1.
